// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_sequencer
//  Purpose  : Priority resolution, CPU INT line, two-pulse INTA handshake,
//             vector return and EOI processing for an 8259A-style PIC.
//             Optional automatic EOI is enabled by defining INTSEQ_AEOI_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
    parameter int VECTOR_BASE_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               irq,
    input  logic                     inta_n,
    input  logic                     eoi,
    input  logic                     seoi,
    input  logic [2:0]               seoi_level,
    input  logic [VECTOR_BASE_W-1:0] vector_base,
    output logic                     int_out,
    output logic [7:0]               isr,
    output logic [7:0]               clear_irr,
    output logic [7:0]               data_out,
    output logic                     data_oe
);

    localparam logic [2:0] c_stIdle  = 3'd0;
    localparam logic [2:0] c_stPend  = 3'd1;
    localparam logic [2:0] c_stAck1  = 3'd2;
    localparam logic [2:0] c_stWait2 = 3'd3;
    localparam logic [2:0] c_stVec   = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_nextState;

    logic       r_intaCur;
    logic       r_intaPrev;
    logic       w_intaFall;
    logic       w_intaRise;

    logic [7:0] r_isr;
    logic [7:0] w_isrLowest;
    logic [7:0] w_allowed;
    logic [7:0] w_qual;
    logic [7:0] w_candOneHot;
    logic       w_candValid;
    logic [2:0] w_candLevel;

    logic [2:0] r_level;
    logic       r_spurious;
    logic       w_ackTake;
    logic [7:0] w_isrSet;
    logic [7:0] w_isrClr;
    logic [7:0] w_aeoiClr;

    logic       w_intOutNext;
    logic [7:0] w_clearIrrNext;
    logic       w_dataOeNext;
    logic [7:0] w_dataOutNext;

    logic       r_intOut;
    logic [7:0] r_clearIrr;
    logic [7:0] r_dataOut;
    logic       r_dataOe;

    // INTA edge detection runs on a registered copy so edges are seen one cycle late
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_intaCur  <= 1'b1;
            r_intaPrev <= 1'b1;
        end else begin
            r_intaCur  <= inta_n;
            r_intaPrev <= r_intaCur;
        end
    end

    assign w_intaFall = r_intaPrev & ~r_intaCur;
    assign w_intaRise = ~r_intaPrev & r_intaCur;

    // A request qualifies only below the lowest-numbered (highest-priority) in-service level
    assign w_isrLowest  = r_isr & (~r_isr + 8'd1);
    assign w_allowed    = (r_isr == 8'd0) ? 8'hFF : (w_isrLowest - 8'd1);
    assign w_qual       = irq & w_allowed;
    assign w_candOneHot = w_qual & (~w_qual + 8'd1);
    assign w_candValid  = |w_qual;

    // Encode the winning candidate; scanning downward lets the lowest index win
    always_comb begin
        w_candLevel = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_candLevel = 3'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic; INTA edges are only meaningful outside IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle:  if (w_candValid) w_nextState = c_stPend;
            c_stPend:  if (w_intaFall)  w_nextState = c_stAck1;
            c_stAck1:  if (w_intaRise)  w_nextState = c_stWait2;
            c_stWait2: if (w_intaFall)  w_nextState = c_stVec;
            c_stVec:   if (w_intaRise)  w_nextState = c_stIdle;
            default:                    w_nextState = c_stIdle;
        endcase
    end

    assign w_ackTake = (r_state == c_stPend) && w_intaFall;
    assign w_isrSet  = (w_ackTake && w_candValid) ? w_candOneHot : 8'd0;

`ifdef INTSEQ_AEOI_EN
    // Automatic EOI retires the served level as the handshake ends
    assign w_aeoiClr = ((r_state == c_stVec) && w_intaRise && !r_spurious)
                       ? (8'd1 << r_level) : 8'd0;
`else
    assign w_aeoiClr = 8'd0;
`endif

    // EOI targets are taken from the pre-update ISR so a coincident set also lands
    assign w_isrClr = (eoi  ? w_isrLowest          : 8'd0)
                    | (seoi ? (8'd1 << seoi_level) : 8'd0)
                    | w_aeoiClr;

    // FSM output decode, computed one cycle ahead so every output is registered
    always_comb begin
        w_intOutNext   = (w_nextState == c_stPend);
        w_clearIrrNext = w_isrSet;
        w_dataOeNext   = (w_nextState == c_stVec);
        w_dataOutNext  = 8'd0;
        if (w_dataOeNext) begin
            w_dataOutNext = 8'({vector_base, r_level});
        end
    end

    // Handshake datapath: latched level, spurious flag, ISR and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level    <= 3'd0;
            r_spurious <= 1'b0;
            r_isr      <= 8'd0;
            r_intOut   <= 1'b0;
            r_clearIrr <= 8'd0;
            r_dataOut  <= 8'd0;
            r_dataOe   <= 1'b0;
        end else begin
            if (w_ackTake) begin
                r_level    <= w_candValid ? w_candLevel : 3'd7;
                r_spurious <= ~w_candValid;
            end
            r_isr      <= (r_isr & ~w_isrClr) | w_isrSet;
            r_intOut   <= w_intOutNext;
            r_clearIrr <= w_clearIrrNext;
            r_dataOut  <= w_dataOutNext;
            r_dataOe   <= w_dataOeNext;
        end
    end

    assign int_out   = r_intOut;
    assign isr       = r_isr;
    assign clear_irr = r_clearIrr;
    assign data_out  = r_dataOut;
    assign data_oe   = r_dataOe;

endmodule
`default_nettype wire
